// File: rtl/fpu_dispatch_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_dispatch_controller_if
// Description : Queue-head, NEU operand bundle and status signals between the
//               FPU instruction queue, the dispatch sequencer and the NEU.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_dispatch_controller_if;
  logic        dispatch_enable;
  logic        abort_req;
  logic        queue_empty;
  logic [7:0]  q_instruction;
  logic [2:0]  q_stack_index;
  logic        q_has_mem;
  logic [1:0]  q_operand_size;
  logic        q_is_integer;
  logic        q_is_bcd;
  logic [79:0] q_data;
  logic        dequeue;
  logic        flush_queue;
  logic        exec_start;
  logic [7:0]  exec_instruction;
  logic [2:0]  exec_stack_index;
  logic        exec_has_mem;
  logic [1:0]  exec_operand_size;
  logic        exec_is_integer;
  logic        exec_is_bcd;
  logic [79:0] exec_data;
  logic        exec_abort;
  logic        exec_done;
  logic        exec_error;
  logic        busy;
  logic        timeout_error;

  modport master (
    input  dispatch_enable, abort_req, queue_empty,
    input  q_instruction, q_stack_index, q_has_mem, q_operand_size,
    input  q_is_integer, q_is_bcd, q_data,
    input  exec_done, exec_error,
    output dequeue, flush_queue, exec_start, exec_abort, busy, timeout_error,
    output exec_instruction, exec_stack_index, exec_has_mem, exec_operand_size,
    output exec_is_integer, exec_is_bcd, exec_data
  );

  modport slave (
    output dispatch_enable, abort_req, queue_empty,
    output q_instruction, q_stack_index, q_has_mem, q_operand_size,
    output q_is_integer, q_is_bcd, q_data,
    output exec_done, exec_error,
    input  dequeue, flush_queue, exec_start, exec_abort, busy, timeout_error,
    input  exec_instruction, exec_stack_index, exec_has_mem, exec_operand_size,
    input  exec_is_integer, exec_is_bcd, exec_data
  );
endinterface
`default_nettype wire

// File: rtl/fpu_dispatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fpu_dispatch_controller
// Description : Pops the FPU queue head, issues it to the NEU, waits for
//               completion under a watchdog and sequences queue flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_dispatch_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  OPC_FINIT      = 8'hF0,
  parameter logic [7:0]  OPC_FLDCW      = 8'hF1
) (
  input  wire                         clk,
  input  wire                         reset,
  fpu_dispatch_controller_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [15:0] c_wdog_last = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_wdog;
  logic        r_exec_start;
  logic        r_flush;
  logic        r_abort;
  logic        r_timeout;

  logic w_dispatch_go;
  logic w_flush_needed;

  assign w_dispatch_go  = (r_state == S_IDLE) & bus.dispatch_enable
                        & ~bus.queue_empty & ~bus.abort_req;
  assign w_flush_needed = bus.exec_error
                        | (bus.exec_instruction == OPC_FINIT)
                        | (bus.exec_instruction == OPC_FLDCW);

  assign bus.dequeue       = w_dispatch_go;
  assign bus.exec_start    = r_exec_start;
  assign bus.flush_queue   = r_flush;
  assign bus.exec_abort    = r_abort;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.timeout_error = r_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state               <= S_IDLE;
      r_wdog                <= 16'd0;
      r_exec_start          <= 1'b0;
      r_flush               <= 1'b0;
      r_abort               <= 1'b0;
      r_timeout             <= 1'b0;
      bus.exec_instruction  <= 8'd0;
      bus.exec_stack_index  <= 3'd0;
      bus.exec_has_mem      <= 1'b0;
      bus.exec_operand_size <= 2'd0;
      bus.exec_is_integer   <= 1'b0;
      bus.exec_is_bcd       <= 1'b0;
      bus.exec_data         <= 80'd0;
    end else begin
      r_exec_start <= 1'b0;
      r_flush      <= 1'b0;
      r_abort      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.abort_req) begin
            r_state <= S_FLUSH;
            r_flush <= 1'b1;
          end else if (w_dispatch_go) begin
            bus.exec_instruction  <= bus.q_instruction;
            bus.exec_stack_index  <= bus.q_stack_index;
            bus.exec_has_mem      <= bus.q_has_mem;
            bus.exec_operand_size <= bus.q_operand_size;
            bus.exec_is_integer   <= bus.q_is_integer;
            bus.exec_is_bcd       <= bus.q_is_bcd;
            bus.exec_data         <= bus.q_data;
            r_wdog                <= 16'd0;
            r_state               <= S_ISSUE;
            r_exec_start          <= 1'b1;
          end
        end
        // ISSUE and WAIT react identically to done/abort/timeout; the
        // watchdog counts from the ISSUE cycle so the timeout lands on
        // exactly TIMEOUT_CYCLES edges after exec_start.
        S_ISSUE, S_WAIT: begin
          r_wdog <= r_wdog + 16'd1;
          if (bus.abort_req) begin
            r_abort <= 1'b1;
            r_state <= S_FLUSH;
            r_flush <= 1'b1;
          end else if (bus.exec_done) begin
            if (w_flush_needed) begin
              r_state <= S_FLUSH;
              r_flush <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (r_wdog == c_wdog_last) begin
            r_timeout <= 1'b1;
            r_abort   <= 1'b1;
            r_state   <= S_FLUSH;
            r_flush   <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_FLUSH: begin
          if (bus.abort_req) begin
            r_flush <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_dispatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_dispatch_controller
// Description : Directed self-checking bench for fpu_dispatch_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_dispatch_controller;

  logic clk;
  logic reset;
  fpu_dispatch_controller_if bus();

  fpu_dispatch_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three-entry queue model, head at index 0
  logic [7:0]  qi [4];
  logic [2:0]  qs [4];
  logic [79:0] qd [4];
  int          qcount;

  assign bus.q_instruction  = qi[0];
  assign bus.q_stack_index  = qs[0];
  assign bus.q_data         = qd[0];
  assign bus.q_has_mem      = 1'b1;
  assign bus.q_operand_size = 2'b10;
  assign bus.q_is_integer   = 1'b0;
  assign bus.q_is_bcd       = 1'b1;
  assign bus.queue_empty    = (qcount == 0);

  int n_pass, n_total;
  int cyc;
  int n_deq, n_start, n_flush, n_abort;
  int st_cyc [16];

  task automatic push(input logic [7:0] op, input logic [2:0] idx, input logic [79:0] d);
    qi[qcount] = op;
    qs[qcount] = idx;
    qd[qcount] = d;
    qcount++;
  endtask

  // Advance one cycle: count events mid-cycle, then update the queue model
  // just after the edge so the DUT latches the old head.
  task automatic step();
    logic pop, fl;
    @(negedge clk);
    pop = bus.dequeue;
    fl  = bus.flush_queue;
    if (bus.dequeue)     n_deq++;
    if (bus.flush_queue) n_flush++;
    if (bus.exec_abort)  n_abort++;
    if (bus.exec_start) begin
      st_cyc[n_start % 16] = cyc;
      n_start++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (reset || fl) begin
      qcount = 0;
    end else if (pop && qcount > 0) begin
      for (int i = 0; i < 3; i++) begin
        qi[i] = qi[i+1];
        qs[i] = qs[i+1];
        qd[i] = qd[i+1];
      end
      qcount--;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_total++;
    if ({bus.dequeue, bus.flush_queue, bus.exec_start, bus.exec_abort, bus.busy, bus.timeout_error} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000",
               {bus.dequeue, bus.flush_queue, bus.exec_start, bus.exec_abort, bus.busy, bus.timeout_error});
    else n_pass++;
    n_total++;
    if (bus.exec_instruction !== 8'd0 || bus.exec_data !== 80'd0 || bus.exec_stack_index !== 3'd0)
      $display("FAIL reset_exec_regs: got instr=%h idx=%0d data=%h want 0",
               bus.exec_instruction, bus.exec_stack_index, bus.exec_data);
    else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    int b_deq, b_flush;
    b_deq = n_deq; b_flush = n_flush;
    bus.dispatch_enable = 1'b1;
    push(8'h10, 3'd3, 80'h1234);
    #1;
    n_total++;
    if (bus.dequeue !== 1'b1) $display("FAIL single_dequeue: got %b want 1", bus.dequeue);
    else n_pass++;
    step();
    n_total++;
    if (bus.exec_start !== 1'b1 || bus.dequeue !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL single_start: got start=%b deq=%b busy=%b want 1 0 1",
               bus.exec_start, bus.dequeue, bus.busy);
    else n_pass++;
    n_total++;
    if (bus.exec_instruction !== 8'h10 || bus.exec_stack_index !== 3'd3 || bus.exec_data !== 80'h1234
        || bus.exec_has_mem !== 1'b1 || bus.exec_operand_size !== 2'b10 || bus.exec_is_bcd !== 1'b1)
      $display("FAIL single_fields: got instr=%h idx=%0d data=%h mem=%b sz=%b bcd=%b want 10 3 1234 1 10 1",
               bus.exec_instruction, bus.exec_stack_index, bus.exec_data,
               bus.exec_has_mem, bus.exec_operand_size, bus.exec_is_bcd);
    else n_pass++;
    step();
    n_total++;
    if (bus.exec_start !== 1'b0) $display("FAIL single_start_pulse: got %b want 0", bus.exec_start);
    else n_pass++;
    step();
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    #1;
    n_total++;
    if (bus.busy !== 1'b0 || bus.flush_queue !== 1'b0)
      $display("FAIL single_complete: got busy=%b flush=%b want 0 0", bus.busy, bus.flush_queue);
    else n_pass++;
    step();
    n_total++;
    if (n_deq - b_deq !== 1 || n_flush - b_flush !== 0)
      $display("FAIL single_counts: got deq=%0d flush=%0d want 1 0", n_deq - b_deq, n_flush - b_flush);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int b_deq, b_st, b_flush;
    b_deq = n_deq; b_st = n_start; b_flush = n_flush;
    push(8'h11, 3'd1, 80'h11);
    push(8'h12, 3'd2, 80'h22);
    push(8'h13, 3'd4, 80'h33);
    bus.exec_done = 1'b1;
    for (int i = 0; i < 8; i++) step();
    bus.exec_done = 1'b0;
    n_total++;
    if (n_deq - b_deq !== 3 || n_start - b_st !== 3 || n_flush - b_flush !== 0)
      $display("FAIL b2b_counts: got deq=%0d start=%0d flush=%0d want 3 3 0",
               n_deq - b_deq, n_start - b_st, n_flush - b_flush);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (st_cyc[(b_st + i + 1) % 16] - st_cyc[(b_st + i) % 16] !== 2)
        $display("FAIL b2b_spacing: got %0d cycles want 2",
                 st_cyc[(b_st + i + 1) % 16] - st_cyc[(b_st + i) % 16]);
      else n_pass++;
    end
    n_total++;
    if (bus.exec_instruction !== 8'h13 || bus.exec_stack_index !== 3'd4)
      $display("FAIL b2b_last: got instr=%h idx=%0d want 13 4", bus.exec_instruction, bus.exec_stack_index);
    else n_pass++;
  endtask

  task automatic test_finit();
    int b_deq, b_flush;
    b_deq = n_deq; b_flush = n_flush;
    push(8'hF0, 3'd0, 80'h0);
    push(8'h30, 3'd5, 80'h55);
    step();
    n_total++;
    if (bus.exec_start !== 1'b1 || bus.exec_instruction !== 8'hF0)
      $display("FAIL finit_issue: got start=%b instr=%h want 1 f0", bus.exec_start, bus.exec_instruction);
    else n_pass++;
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    #1;
    n_total++;
    if (bus.flush_queue !== 1'b1 || bus.dequeue !== 1'b0)
      $display("FAIL finit_flush: got flush=%b deq=%b want 1 0", bus.flush_queue, bus.dequeue);
    else n_pass++;
    step();
    n_total++;
    if (bus.flush_queue !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL finit_flush_len: got flush=%b busy=%b want 0 0", bus.flush_queue, bus.busy);
    else n_pass++;
    step();
    n_total++;
    if (n_deq - b_deq !== 1 || n_flush - b_flush !== 1)
      $display("FAIL finit_counts: got deq=%0d flush=%0d want 1 1", n_deq - b_deq, n_flush - b_flush);
    else n_pass++;
  endtask

  task automatic test_error();
    push(8'h20, 3'd2, 80'hABC);
    step();
    step();
    bus.exec_done  = 1'b1;
    bus.exec_error = 1'b1;
    step();
    bus.exec_done  = 1'b0;
    bus.exec_error = 1'b0;
    #1;
    n_total++;
    if (bus.flush_queue !== 1'b1 || bus.timeout_error !== 1'b0 || bus.exec_abort !== 1'b0)
      $display("FAIL error_flush: got flush=%b tmo=%b abort=%b want 1 0 0",
               bus.flush_queue, bus.timeout_error, bus.exec_abort);
    else n_pass++;
    step();
    n_total++;
    if (bus.flush_queue !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL error_after: got flush=%b busy=%b want 0 0", bus.flush_queue, bus.busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    push(8'h40, 3'd6, 80'h77);
    step();
    n_total++;
    if (bus.exec_start !== 1'b1) $display("FAIL tmo_start: got %b want 1", bus.exec_start);
    else n_pass++;
    for (int i = 1; i < 8; i++) begin
      step();
      n_total++;
      if (bus.exec_abort !== 1'b0 || bus.flush_queue !== 1'b0 || bus.timeout_error !== 1'b0)
        $display("FAIL tmo_early: cycle S+%0d got abort=%b flush=%b tmo=%b want 0 0 0",
                 i, bus.exec_abort, bus.flush_queue, bus.timeout_error);
      else n_pass++;
    end
    step();
    n_total++;
    if (bus.exec_abort !== 1'b1 || bus.flush_queue !== 1'b1 || bus.timeout_error !== 1'b1)
      $display("FAIL tmo_fire: got abort=%b flush=%b tmo=%b want 1 1 1",
               bus.exec_abort, bus.flush_queue, bus.timeout_error);
    else n_pass++;
    step();
    n_total++;
    if (bus.exec_abort !== 1'b0 || bus.flush_queue !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL tmo_after: got abort=%b flush=%b busy=%b want 0 0 0",
               bus.exec_abort, bus.flush_queue, bus.busy);
    else n_pass++;
    step();
    step();
    n_total++;
    if (bus.timeout_error !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", bus.timeout_error);
    else n_pass++;
  endtask

  task automatic test_abort_done();
    int b_deq, b_flush, b_abort;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_total++;
    if (bus.timeout_error !== 1'b0) $display("FAIL abort_tmo_cleared: got %b want 0", bus.timeout_error);
    else n_pass++;
    bus.dispatch_enable = 1'b1;
    push(8'h50, 3'd1, 80'h5);
    push(8'h51, 3'd2, 80'h6);
    step();
    bus.dispatch_enable = 1'b0;
    b_deq = n_deq; b_flush = n_flush; b_abort = n_abort;
    step();
    bus.abort_req = 1'b1;
    bus.exec_done = 1'b1;
    step();
    bus.abort_req = 1'b0;
    bus.exec_done = 1'b0;
    #1;
    n_total++;
    if (bus.exec_abort !== 1'b1 || bus.flush_queue !== 1'b1)
      $display("FAIL abort_pulse: got abort=%b flush=%b want 1 1", bus.exec_abort, bus.flush_queue);
    else n_pass++;
    step();
    push(8'h52, 3'd3, 80'h7);
    #1;
    n_total++;
    if (bus.exec_abort !== 1'b0 || bus.flush_queue !== 1'b0 || bus.busy !== 1'b0 || bus.dequeue !== 1'b0)
      $display("FAIL abort_after: got abort=%b flush=%b busy=%b deq=%b want 0 0 0 0",
               bus.exec_abort, bus.flush_queue, bus.busy, bus.dequeue);
    else n_pass++;
    for (int i = 0; i < 3; i++) step();
    n_total++;
    if (n_abort - b_abort !== 1 || n_flush - b_flush !== 1 || n_deq - b_deq !== 0)
      $display("FAIL abort_counts: got abort=%0d flush=%0d deq=%0d want 1 1 0",
               n_abort - b_abort, n_flush - b_flush, n_deq - b_deq);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    n_deq = 0; n_start = 0; n_flush = 0; n_abort = 0;
    qcount = 0;
    for (int i = 0; i < 4; i++) begin
      qi[i] = 8'd0; qs[i] = 3'd0; qd[i] = 80'd0;
    end
    for (int i = 0; i < 16; i++) st_cyc[i] = 0;
    reset               = 1'b1;
    bus.dispatch_enable = 1'b0;
    bus.abort_req       = 1'b0;
    bus.exec_done       = 1'b0;
    bus.exec_error      = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_finit();
    test_error();
    test_timeout();
    test_abort_done();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not finish, got no end want end");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
`default_nettype wire
